ram_param_clr: RTL and testbench

RAM_PARAM_CLR -- requirements
Module: ram_param_clr

---
 rtl/ram_pkg.sv | 13 +
 rtl/ram_clear_seq.sv | 78 +++++++
 rtl/ram_param_clr.sv | 76 +++++++
 tb/tb_ram_param_clr.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared definitions for the clearable parameterised RAM: default geometry
// and the clear-sequencer state encoding.
package ram_pkg;

    localparam int DEFAULT_WIDTH  = 16;
    localparam int DEFAULT_ADDR_W = 9;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/ram_clear_seq.sv
// Clear sequencer: walks a pointer across every word of the array, one word
// per clock, and tells the top level when the write port belongs to it.
// Reset drops straight into a clear pass so the array always starts zeroed.
module ram_clear_seq
    import ram_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    output logic              busy,
    output logic              clear_done,
    output logic              clr_sel,
    output logic [ADDR_W-1:0] clr_ptr
);

    // Last word of the array; reaching it ends the pass without wrapping.
    localparam logic [ADDR_W-1:0] LAST_PTR = '1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // Next-state logic: a clear request starts a pass, the last word ends it.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (clear) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            CLEAR: begin
                if (ptr_q == LAST_PTR) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    ptr_d = ptr_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = CLEAR;
                ptr_d   = '0;
                busy_d  = 1'b1;
            end
        endcase
    end

    // State registers; reset forces a fresh clear pass from word zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy       = busy_q;
    assign clear_done = done_q;
    assign clr_ptr    = ptr_q;
    assign clr_sel    = (state_q == CLEAR);

endmodule

// File: rtl/ram_param_clr.sv
// Single-port RAM with asynchronous read and a hardware clear sequencer.
// The array has no reset so it can map to block RAM; zeroing is done by
// the sequencer taking over the write port one word per clock.
module ram_param_clr
    import ram_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [WIDTH-1:0]  in,
    input  logic              load,
    input  logic [ADDR_W-1:0] address,
    input  logic              clear,
    output logic [WIDTH-1:0]  out,
    output logic              busy,
    output logic              clear_done
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0]  mem [DEPTH];

    logic              clr_sel;
    logic [ADDR_W-1:0] clr_ptr;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;

    ram_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_seq (
        .clk        (CLK),
        .rst        (RST),
        .clear      (clear),
        .busy       (busy),
        .clear_done (clear_done),
        .clr_sel    (clr_sel),
        .clr_ptr    (clr_ptr)
    );

    // Write-port mux: the sequencer owns the port while clearing; a user
    // write loses to a simultaneous clear request and to reset.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = address;
        wr_data = in;
        if (clr_sel) begin
            wr_en   = 1'b1;
            wr_addr = clr_ptr;
            wr_data = '0;
        end else begin
            wr_en = load & ~clear;
        end
        if (RST) begin
            wr_en = 1'b0;
        end
    end

    // Array storage, deliberately without reset.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Combinational read, blanked to zero while a clear pass runs.
    always_comb begin
        out = mem[address];
        if (clr_sel) begin
            out = '0;
        end
    end

endmodule

// File: tb/tb_ram_param_clr.sv
// Self-checking bench for ram_param_clr (WIDTH=16, ADDR_W=9) with a
// behavioural array model and randomised data/addresses.
module tb_ram_param_clr;

    localparam int WIDTH    = 16;
    localparam int ADDR_W   = 9;
    localparam int DEPTH    = 512;
    localparam int MAX_WAIT = 2000;

    logic              CLK = 1'b0;
    logic              RST = 1'b0;
    logic [WIDTH-1:0]  din = '0;
    logic              load = 1'b0;
    logic [ADDR_W-1:0] address = '0;
    logic              clear = 1'b0;
    logic [WIDTH-1:0]  dout;
    logic              busy;
    logic              clear_done;

    int check_cnt = 0;
    int pass_cnt  = 0;

    logic [WIDTH-1:0] model [DEPTH];

    ram_param_clr #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .in         (din),
        .load       (load),
        .address    (address),
        .clear      (clear),
        .out        (dout),
        .busy       (busy),
        .clear_done (clear_done)
    );

    // Free-running clock, 10 ns period.
    initial forever #5 CLK = ~CLK;

    // Absolute watchdog so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance to 2 ns after the next rising edge (drive and sample window).
    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    // Zero the whole model, as a completed clear pass does.
    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    // Let a running clear pass finish, measuring it. Optionally re-request
    // clear at a given cycle and hammer the write port with random writes.
    task automatic run_clear(input int reassert_at, input bit scramble,
                             output int cycles, output int pulses,
                             output int nonzero_out, output bit done_at_fall);
        cycles = 0; pulses = 0; nonzero_out = 0; done_at_fall = 1'b0;
        while (busy === 1'b1 && cycles < MAX_WAIT) begin
            if (scramble) begin
                load    = 1'b1;
                address = ADDR_W'($urandom);
                din     = WIDTH'($urandom) | 16'h0001;
                #1;
            end
            if (dout !== '0) nonzero_out++;
            if (clear_done === 1'b1) pulses++;
            clear = (cycles == reassert_at);
            step();
            cycles++;
        end
        load  = 1'b0;
        clear = 1'b0;
        done_at_fall = (clear_done === 1'b1);
        for (int k = 0; k < 4; k++) begin
            if (clear_done === 1'b1) pulses++;
            step();
        end
    endtask

    // Reset: immediate busy/out/clear_done values, then a full clear pass.
    task automatic test_reset();
        int cyc, pul, nz;
        bit daf;
        step(); step();
        #1 RST = 1'b1;
        #1;
        check_cnt++; if (busy !== 1'b1) $display("[TB] FAIL reset_busy: got %b want 1", busy); else pass_cnt++;
        check_cnt++; if (dout !== '0) $display("[TB] FAIL reset_out: got %h want 0000", dout); else pass_cnt++;
        check_cnt++; if (clear_done !== 1'b0) $display("[TB] FAIL reset_done: got %b want 0", clear_done); else pass_cnt++;
        step();
        RST = 1'b0;
        run_clear(-1, 1'b0, cyc, pul, nz, daf);
        model_clear();
        check_cnt++; if (cyc != DEPTH) $display("[TB] FAIL reset_busy_len: got %0d want %0d", cyc, DEPTH); else pass_cnt++;
        check_cnt++; if (pul != 1) $display("[TB] FAIL reset_done_pulses: got %0d want 1", pul); else pass_cnt++;
        check_cnt++; if (!daf) $display("[TB] FAIL reset_done_at_fall: got 0 want 1"); else pass_cnt++;
        check_cnt++; if (nz != 0) $display("[TB] FAIL reset_out_zero: got %0d nonzero cycles want 0", nz); else pass_cnt++;
        for (int a = 0; a < DEPTH; a++) begin
            address = ADDR_W'(a);
            #1;
            check_cnt++; if (dout !== model[a]) $display("[TB] FAIL reset_read[%0d]: got %h want %h", a, dout, model[a]); else pass_cnt++;
        end
    endtask

    // Fill every word with its own address, then read all of them back.
    task automatic test_fill_readback();
        for (int a = 0; a < DEPTH; a++) begin
            address = ADDR_W'(a);
            din     = WIDTH'(a);
            load    = 1'b1;
            step();
            model[a] = WIDTH'(a);
            check_cnt++; if (dout !== model[a]) $display("[TB] FAIL fill_write[%0d]: got %h want %h", a, dout, model[a]); else pass_cnt++;
        end
        load = 1'b0;
        for (int a = DEPTH - 1; a >= 0; a--) begin
            address = ADDR_W'(a);
            #1;
            check_cnt++; if (dout !== model[a]) $display("[TB] FAIL fill_read[%0d]: got %h want %h", a, dout, model[a]); else pass_cnt++;
        end
    endtask

    // Clear requested together with a write: the write must be dropped.
    task automatic test_clear_drops_load();
        int cyc, pul, nz;
        bit daf;
        address = ADDR_W'(5);
        din     = 16'hBEEF;
        load    = 1'b1;
        clear   = 1'b1;
        step();
        load  = 1'b0;
        clear = 1'b0;
        check_cnt++; if (busy !== 1'b1) $display("[TB] FAIL cdl_busy_start: got %b want 1", busy); else pass_cnt++;
        run_clear(-1, 1'b0, cyc, pul, nz, daf);
        model_clear();
        check_cnt++; if (cyc != DEPTH) $display("[TB] FAIL cdl_busy_len: got %0d want %0d", cyc, DEPTH); else pass_cnt++;
        check_cnt++; if (pul != 1) $display("[TB] FAIL cdl_done_pulses: got %0d want 1", pul); else pass_cnt++;
        check_cnt++; if (!daf) $display("[TB] FAIL cdl_done_at_fall: got 0 want 1"); else pass_cnt++;
        check_cnt++; if (nz != 0) $display("[TB] FAIL cdl_out_zero: got %0d nonzero cycles want 0", nz); else pass_cnt++;
        address = ADDR_W'(5);
        #1;
        check_cnt++; if (dout !== model[5]) $display("[TB] FAIL cdl_read5: got %h want %h", dout, model[5]); else pass_cnt++;
        for (int i = 0; i < 16; i++) begin
            int a;
            a = int'($urandom_range(DEPTH - 1, 0));
            address = ADDR_W'(a);
            #1;
            check_cnt++; if (dout !== model[a]) $display("[TB] FAIL cdl_read[%0d]: got %h want %h", a, dout, model[a]); else pass_cnt++;
        end
    endtask

    // Random mix of writes and idle cycles checked against the model.
    task automatic test_random_ops();
        for (int i = 0; i < 300; i++) begin
            int a;
            a       = int'($urandom_range(DEPTH - 1, 0));
            address = ADDR_W'(a);
            din     = WIDTH'($urandom);
            load    = $urandom_range(1, 0) == 1;
            step();
            if (load) model[a] = din;
            check_cnt++; if (dout !== model[a]) $display("[TB] FAIL rand_op[%0d] addr %0d: got %h want %h", i, a, dout, model[a]); else pass_cnt++;
        end
        load = 1'b0;
    endtask

    // Re-requested clear and continuous writes during a pass are ignored.
    task automatic test_clear_ignored();
        int cyc, pul, nz;
        bit daf;
        clear   = 1'b1;
        load    = 1'b1;
        din     = 16'hA5A5;
        address = ADDR_W'($urandom);
        step();
        clear = 1'b0;
        run_clear(100, 1'b1, cyc, pul, nz, daf);
        model_clear();
        check_cnt++; if (cyc != DEPTH) $display("[TB] FAIL ign_busy_len: got %0d want %0d", cyc, DEPTH); else pass_cnt++;
        check_cnt++; if (pul != 1) $display("[TB] FAIL ign_done_pulses: got %0d want 1", pul); else pass_cnt++;
        check_cnt++; if (!daf) $display("[TB] FAIL ign_done_at_fall: got 0 want 1"); else pass_cnt++;
        check_cnt++; if (nz != 0) $display("[TB] FAIL ign_out_zero: got %0d nonzero cycles want 0", nz); else pass_cnt++;
        for (int a = 0; a < DEPTH; a++) begin
            address = ADDR_W'(a);
            #1;
            check_cnt++; if (dout !== model[a]) $display("[TB] FAIL ign_read[%0d]: got %h want %h", a, dout, model[a]); else pass_cnt++;
        end
    endtask

    // Reset part-way through a pass restarts it from word zero.
    task automatic test_reset_mid_clear();
        int cyc, pul, nz, early;
        bit daf;
        address = ADDR_W'(400);
        din     = 16'h1234;
        load    = 1'b1;
        step();
        load = 1'b0;
        model[400] = 16'h1234;
        check_cnt++; if (dout !== model[400]) $display("[TB] FAIL rmc_write400: got %h want %h", dout, model[400]); else pass_cnt++;
        clear = 1'b1;
        step();
        clear = 1'b0;
        early = 0;
        for (int i = 0; i < 300; i++) begin
            if (busy !== 1'b1) early++;
            step();
        end
        check_cnt++; if (early != 0) $display("[TB] FAIL rmc_busy_before_rst: got %0d idle cycles want 0", early); else pass_cnt++;
        #1 RST = 1'b1;
        #1;
        check_cnt++; if (busy !== 1'b1) $display("[TB] FAIL rmc_rst_busy: got %b want 1", busy); else pass_cnt++;
        check_cnt++; if (dout !== '0) $display("[TB] FAIL rmc_rst_out: got %h want 0000", dout); else pass_cnt++;
        step();
        RST = 1'b0;
        run_clear(-1, 1'b0, cyc, pul, nz, daf);
        model_clear();
        check_cnt++; if (cyc != DEPTH) $display("[TB] FAIL rmc_busy_len: got %0d want %0d", cyc, DEPTH); else pass_cnt++;
        check_cnt++; if (pul != 1) $display("[TB] FAIL rmc_done_pulses: got %0d want 1", pul); else pass_cnt++;
        address = ADDR_W'(400);
        #1;
        check_cnt++; if (dout !== model[400]) $display("[TB] FAIL rmc_read400: got %h want %h", dout, model[400]); else pass_cnt++;
    endtask

    // Top-address boundary: word 511 holds its value, word 0 is untouched.
    task automatic test_top_boundary();
        address = ADDR_W'(DEPTH - 1);
        din     = 16'hFFFF;
        load    = 1'b1;
        step();
        load = 1'b0;
        model[DEPTH - 1] = 16'hFFFF;
        check_cnt++; if (dout !== model[DEPTH - 1]) $display("[TB] FAIL top_read511: got %h want %h", dout, model[DEPTH - 1]); else pass_cnt++;
        address = ADDR_W'(0);
        #1;
        check_cnt++; if (dout !== model[0]) $display("[TB] FAIL top_read0: got %h want %h", dout, model[0]); else pass_cnt++;
        check_cnt++; if (busy !== 1'b0) $display("[TB] FAIL top_busy_idle: got %b want 0", busy); else pass_cnt++;
    endtask

    // Scenario sequence and summary.
    initial begin
        model_clear();
        test_reset();
        test_fill_readback();
        test_clear_drops_load();
        test_random_ops();
        test_clear_ignored();
        test_reset_mid_clear();
        test_top_boundary();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
